// File: rtl/mseq_sync_pkg.sv
// +----------------------------------------------------------------------+
// | mseq_pkg : shared types, constants and helpers for mseq_sync          |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mseq_pkg;

  localparam int MSEQ_DEG    = 5;
  localparam int MSEQ_PERIOD = 31;

  localparam logic [MSEQ_DEG-1:0] DEF_TAPS      = 5'b10100;
  localparam logic [MSEQ_DEG-1:0] DEF_REF_STATE = 5'b11111;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } mseq_state_e;

  function automatic logic [MSEQ_DEG-1:0] lfsr_advance(
    input logic [MSEQ_DEG-1:0] s,
    input logic [MSEQ_DEG-1:0] taps
  );
    return {s[MSEQ_DEG-2:0], ^(s & taps)};
  endfunction

  // Index of state s along the sequence that starts at ref_st (phase 0).
  function automatic logic [MSEQ_DEG-1:0] state_to_phase(
    input logic [MSEQ_DEG-1:0] s,
    input logic [MSEQ_DEG-1:0] taps,
    input logic [MSEQ_DEG-1:0] ref_st
  );
    logic [MSEQ_DEG-1:0] cur;
    logic [MSEQ_DEG-1:0] idx;
    cur = ref_st;
    idx = '0;
    for (int k = 0; k < MSEQ_PERIOD; k++) begin
      if (cur == s) idx = MSEQ_DEG'(k);
      cur = lfsr_advance(cur, taps);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mseq_sync_if.sv
// +----------------------------------------------------------------------+
// | mseq_sync_if : chip stream in, lock/phase/error status out            |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

interface mseq_sync_if;
  logic        chip_in;
  logic        chip_en;
  logic        locked;
  logic [4:0]  phase;
  logic        period_start;
  logic        chip_err;
  logic [5:0]  win_errs;
  logic [15:0] total_errs;

  modport master (
    output chip_in, chip_en,
    input  locked, phase, period_start, chip_err, win_errs, total_errs
  );

  modport slave (
    input  chip_in, chip_en,
    output locked, phase, period_start, chip_err, win_errs, total_errs
  );
endinterface

`default_nettype wire

// File: rtl/mseq_lfsr_pred.sv
// +----------------------------------------------------------------------+
// | mseq_lfsr_pred : combinational chip prediction and flywheel advance   |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module mseq_lfsr_pred
  import mseq_pkg::*;
#(
  parameter logic [MSEQ_DEG-1:0] TAPS = DEF_TAPS
) (
  input  logic [MSEQ_DEG-1:0] lfsr,
  output logic                pred,
  output logic [MSEQ_DEG-1:0] lfsr_adv
);

  assign pred     = ^(lfsr & TAPS);
  assign lfsr_adv = {lfsr[MSEQ_DEG-2:0], pred};

endmodule

`default_nettype wire

// File: rtl/mseq_sync.sv
// +----------------------------------------------------------------------+
// | mseq_sync : m-sequence self-synchroniser with lock and error stats    |
// | Optional  : MSEQ_SYNC_ERR_STATS_EN enables the total_errs counter     |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module mseq_sync
  import mseq_pkg::*;
#(
  parameter logic [MSEQ_DEG-1:0] TAPS       = DEF_TAPS,
  parameter int                  VERIFY_LEN = 8,
  parameter int                  ERR_THR    = 3,
  parameter logic [MSEQ_DEG-1:0] REF_STATE  = DEF_REF_STATE
) (
  input  logic        clk,
  input  logic        rst,
  mseq_sync_if.slave  bus
);

  mseq_state_e         state_q, state_d;
  logic [4:0]          lfsr_q, lfsr_d;
  logic [2:0]          load_cnt_q, load_cnt_d;
  logic [4:0]          ok_cnt_q, ok_cnt_d;
  logic [4:0]          win_cnt_q, win_cnt_d;
  logic [5:0]          err_acc_q, err_acc_d;
  logic [4:0]          phase_q, phase_d;
  logic                period_start_q, period_start_d;
  logic                chip_err_q, chip_err_d;
  logic [5:0]          win_errs_q, win_errs_d;

  logic                pred;
  logic [4:0]          lfsr_adv;
  logic [4:0]          lfsr_shift;
  logic                mismatch;
  logic [5:0]          err_now;

  mseq_lfsr_pred #(.TAPS(TAPS)) u_pred (
    .lfsr     (lfsr_q),
    .pred     (pred),
    .lfsr_adv (lfsr_adv)
  );

  assign lfsr_shift = {lfsr_q[3:0], bus.chip_in};
  assign mismatch   = (bus.chip_in != pred);
  assign err_now    = (mismatch && err_acc_q != 6'd63) ? err_acc_q + 6'd1 : err_acc_q;

  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    load_cnt_d     = load_cnt_q;
    ok_cnt_d       = ok_cnt_q;
    win_cnt_d      = win_cnt_q;
    err_acc_d      = err_acc_q;
    phase_d        = phase_q;
    period_start_d = 1'b0;
    chip_err_d     = 1'b0;
    win_errs_d     = win_errs_q;
    if (bus.chip_en) begin
      case (state_q)
        HUNT: begin
          lfsr_d = lfsr_shift;
          if (load_cnt_q == 3'd4) begin
            load_cnt_d = '0;
            if (lfsr_shift != '0) begin
              state_d  = VERIFY;
              ok_cnt_d = '0;
            end
          end else begin
            load_cnt_d = load_cnt_q + 3'd1;
          end
        end
        VERIFY: begin
          if (!mismatch) begin
            lfsr_d   = lfsr_adv;
            ok_cnt_d = ok_cnt_q + 5'd1;
            if (ok_cnt_q == 5'(VERIFY_LEN - 1)) begin
              state_d   = LOCK;
              win_cnt_d = '0;
              err_acc_d = '0;
              phase_d   = state_to_phase(lfsr_adv, TAPS, REF_STATE);
            end
          end else begin
            // The failing chip is the first chip of a fresh load.
            state_d    = HUNT;
            lfsr_d     = lfsr_shift;
            load_cnt_d = 3'd1;
          end
        end
        LOCK: begin
          lfsr_d         = lfsr_adv;
          period_start_d = (lfsr_adv == REF_STATE);
          phase_d        = (lfsr_adv == REF_STATE || phase_q == 5'd30) ? 5'd0 : phase_q + 5'd1;
          chip_err_d     = mismatch;
          if (win_cnt_q == 5'd30) begin
            win_cnt_d  = '0;
            win_errs_d = err_now;
            err_acc_d  = '0;
            if (err_now > 6'(ERR_THR)) begin
              state_d    = HUNT;
              load_cnt_d = '0;
            end
          end else begin
            win_cnt_d = win_cnt_q + 5'd1;
            err_acc_d = err_now;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= HUNT;
      lfsr_q         <= '0;
      load_cnt_q     <= '0;
      ok_cnt_q       <= '0;
      win_cnt_q      <= '0;
      err_acc_q      <= '0;
      phase_q        <= '0;
      period_start_q <= 1'b0;
      chip_err_q     <= 1'b0;
      win_errs_q     <= '0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      load_cnt_q     <= load_cnt_d;
      ok_cnt_q       <= ok_cnt_d;
      win_cnt_q      <= win_cnt_d;
      err_acc_q      <= err_acc_d;
      phase_q        <= phase_d;
      period_start_q <= period_start_d;
      chip_err_q     <= chip_err_d;
      win_errs_q     <= win_errs_d;
    end
  end

`ifdef MSEQ_SYNC_ERR_STATS_EN
  logic [15:0] total_errs_q, total_errs_d;

  always_comb begin
    total_errs_d = total_errs_q;
    if (chip_err_d && total_errs_q != 16'hFFFF) total_errs_d = total_errs_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) total_errs_q <= '0;
    else     total_errs_q <= total_errs_d;
  end

  assign bus.total_errs = total_errs_q;
`else
  assign bus.total_errs = '0;
`endif

  assign bus.locked       = (state_q == LOCK);
  assign bus.phase        = phase_q;
  assign bus.period_start = period_start_q;
  assign bus.chip_err     = chip_err_q;
  assign bus.win_errs     = win_errs_q;

endmodule

`default_nettype wire
